axis_rr_arbiter: RTL

- N-input round-robin AXI-Stream arbiter with packet (tlast) locking.
- Lets several producers share one AXI-Stream consumer. The typical consumer is the write side of an async FIFO or a single DMA channel.
- The output is a registered slice, so `m_tvalid`, `m_tdata` and `m_tlast` come from flops and never depend combinationally on `s_*`.

---
 rtl/axis_arb_pkg.sv | 37 +++
 rtl/axis_rr_arbiter_pick.sv | 24 ++
 rtl/axis_rr_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream arbiter library.
//   arb_state_t : two-state arbiter FSM encoding (IDLE / GRANT)
//   rr_next     : round-robin successor search over a request vector
//   ARB_MAX_N   : largest requester count any arbiter in the library supports
package axis_arb_pkg;

    localparam int unsigned ARB_MAX_N = 16;
    localparam int unsigned ARB_IDX_W = $clog2(ARB_MAX_N);

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // First set request strictly after 'last', wrapping mod n (not mod 2^width).
    // Scanning from the far end lets the nearest candidate overwrite the others,
    // so no early exit is needed. Returns 'last' when nothing is requested.
    function automatic int unsigned rr_next(
        input logic [ARB_MAX_N-1:0] req,
        input int unsigned          last,
        input int unsigned          n
    );
        int unsigned sel;
        int unsigned cand;
        sel = last;
        for (int unsigned k = ARB_MAX_N; k >= 1; k--) begin
            if (k <= n) begin
                cand = (last + k) % n;
                if (req[ARB_IDX_W'(cand)]) begin
                    sel = cand;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req   [N]  : request vector
//   last  [IW] : previous winner; search starts at last+1, wrapping mod N
//   idx   [IW] : selected requester (valid only when found)
//   found      : at least one request is set
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Zero-extend to the library maximum so one helper serves every N.
    always_comb begin
        idx   = IW'(rr_next(ARB_MAX_N'(req), 32'(last), N));
        found = |req;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-input round-robin AXI-Stream arbiter with packet locking.
// A requester keeps the grant until its tlast beat is accepted; the output is
// a registered slice so m_* never depend combinationally on s_*.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   s_tvalid/tready/tdata/tlast : N slave streams (tdata lane i at [i*DW +: DW])
//   m_tvalid/tready/tdata/tlast : single registered master stream
//   m_tid              : source index of each output beat (AXIS_RR_ARBITER_TID_EN only)
//   grant              : current or most recent owner
//   busy               : high while a packet owns the output
// Build option: define AXIS_RR_ARBITER_TID_EN to add the m_tid output.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned DW = 24,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tlast,
`ifdef AXIS_RR_ARBITER_TID_EN
    output logic [IW-1:0]   m_tid,
`endif
    output logic [IW-1:0]   grant,
    output logic            busy
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tlast_q, m_tlast_d;
`ifdef AXIS_RR_ARBITER_TID_EN
    logic [IW-1:0] m_tid_q, m_tid_d;
`endif

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          slot_ready;
    logic          beat_xfer;
    logic [DW-1:0] beat_data;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (s_tvalid),
        .last (grant_q),
        .idx  (pick_idx),
        .found(pick_found)
    );

    // Output slot can take a beat when empty or draining this cycle.
    assign slot_ready = ~m_tvalid_q | m_tready;
    assign beat_xfer  = (state_q == ARB_GRANT) & s_tvalid[grant_q] & slot_ready;
    assign beat_data  = s_tdata[grant_q*DW +: DW];

    // State register: FSM state and owner index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next state: arbitrate in IDLE, release the lock on an accepted tlast.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (beat_xfer && s_tlast[grant_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: owner's ready and the output slice load/drain.
    always_comb begin
        s_tready   = '0;
        busy       = (state_q == ARB_GRANT);
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
`ifdef AXIS_RR_ARBITER_TID_EN
        m_tid_d    = m_tid_q;
`endif
        if (state_q == ARB_GRANT) begin
            s_tready[grant_q] = slot_ready;
        end
        // Load wins over drain so back-to-back beats keep 1 beat/cycle.
        if (beat_xfer) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = beat_data;
            m_tlast_d  = s_tlast[grant_q];
`ifdef AXIS_RR_ARBITER_TID_EN
            m_tid_d    = grant_q;
`endif
        end else if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Output slice register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
`ifdef AXIS_RR_ARBITER_TID_EN
            m_tid_q    <= '0;
`endif
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
`ifdef AXIS_RR_ARBITER_TID_EN
            m_tid_q    <= m_tid_d;
`endif
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tlast  = m_tlast_q;
    assign grant    = grant_q;
`ifdef AXIS_RR_ARBITER_TID_EN
    assign m_tid    = m_tid_q;
`endif

endmodule
